// File: rtl/rob_pkg.sv
// Shared encodings and default widths for the reorder buffer slice.
// Kind and store-size encodings match the decoder and LSB interfaces.
package rob_pkg;

  localparam int DEPTH_DEF    = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_WB_DEF   = 2;
  localparam int BP_IDX_W_DEF = 8;

  typedef enum logic [2:0] {
    KIND_REG  = 3'd0,
    KIND_BR   = 3'd1,
    KIND_JALR = 3'd2,
    KIND_SB   = 3'd3,
    KIND_SH   = 3'd4,
    KIND_SW   = 3'd5
  } rob_kind_e;

  localparam logic [1:0] REQUIRE8  = 2'd0;
  localparam logic [1:0] REQUIRE16 = 2'd1;
  localparam logic [1:0] REQUIRE32 = 2'd2;

  function automatic logic [1:0] store_size(input rob_kind_e kind);
    case (kind)
      KIND_SB: store_size = REQUIRE8;
      KIND_SH: store_size = REQUIRE16;
      default: store_size = REQUIRE32;
    endcase
  endfunction

endpackage

// File: rtl/rob_wb_match.sv
// NUM_WB-way writeback tag comparator; the highest matching channel index wins.
module rob_wb_match
  import rob_pkg::*;
#(
  parameter int NUM_WB = NUM_WB_DEF,
  parameter int TAG_W  = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [TAG_W-1:0]         query_tag,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_value,
  input  logic [NUM_WB*DATA_W-1:0] wb_target,
  input  logic [NUM_WB*DATA_W-1:0] wb_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        value,
  output logic [DATA_W-1:0]        target,
  output logic [DATA_W-1:0]        addr
);

  logic [NUM_WB-1:0] match_s;

  for (genvar c = 0; c < NUM_WB; c++) begin : g_cmp
    assign match_s[c] = wb_valid[c] && (wb_tag[c*TAG_W +: TAG_W] == query_tag);
  end

  // Priority select: later (higher) channels overwrite earlier matches.
  always_comb begin
    hit    = 1'b0;
    value  = {DATA_W{1'b0}};
    target = {DATA_W{1'b0}};
    addr   = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_WB; i++) begin
      hit    = match_s[i] ? 1'b1 : hit;
      value  = match_s[i] ? wb_value[i*DATA_W +: DATA_W] : value;
      target = match_s[i] ? wb_target[i*DATA_W +: DATA_W] : target;
      addr   = match_s[i] ? wb_addr[i*DATA_W +: DATA_W] : addr;
    end
  end

endmodule

// File: rtl/rob_queue.sv
// In-order commit reorder buffer with N writeback channels, operand bypass,
// registered commit outputs and a store handshake that holds the head until acknowledged.
module rob_queue
  import rob_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_WB   = NUM_WB_DEF,
  parameter int BP_IDX_W = BP_IDX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [2:0]               alloc_kind,
  input  logic [4:0]               alloc_rd,
  input  logic [DATA_W-1:0]        alloc_pc,
  input  logic                     alloc_pred_taken,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_value,
  input  logic [NUM_WB*DATA_W-1:0] wb_target,
  input  logic [NUM_WB*DATA_W-1:0] wb_addr,
  input  logic [TAG_W-1:0]         rs1_tag,
  input  logic [TAG_W-1:0]         rs2_tag,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [DATA_W-1:0]        rs1_value,
  output logic [DATA_W-1:0]        rs2_value,
  output logic                     reg_we,
  output logic [4:0]               reg_rd,
  output logic [DATA_W-1:0]        reg_value,
  output logic [TAG_W-1:0]         reg_tag,
  output logic                     st_valid,
  output logic [1:0]               st_size,
  output logic [DATA_W-1:0]        st_addr,
  output logic [DATA_W-1:0]        st_value,
  input  logic                     st_done,
  output logic                     bp_update,
  output logic [BP_IDX_W-1:0]      bp_idx,
  output logic                     bp_taken,
  output logic                     flush,
  output logic [DATA_W-1:0]        flush_pc,
  output logic [TAG_W:0]           count
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head_r, tail_r;
  logic [TAG_W:0]    count_r;
  logic [DEPTH-1:0]  valid_r, ready_r, pred_r;
  rob_kind_e         kind_r   [DEPTH];
  logic [4:0]        rd_r     [DEPTH];
  logic [DATA_W-1:0] pc_r     [DEPTH];
  logic [DATA_W-1:0] value_r  [DEPTH];
  logic [DATA_W-1:0] target_r [DEPTH];
  logic [DATA_W-1:0] addr_r   [DEPTH];

  logic                reg_we_r, st_valid_r, bp_update_r, bp_taken_r, flush_r;
  logic [4:0]          reg_rd_r;
  logic [DATA_W-1:0]   reg_value_r, st_addr_r, st_value_r, flush_pc_r;
  logic [TAG_W-1:0]    reg_tag_r;
  logic [1:0]          st_size_r;
  logic [BP_IDX_W-1:0] bp_idx_r;

  logic [DEPTH-1:0]  ent_hit_s, wb_we_s;
  logic [DATA_W-1:0] ent_value_s  [DEPTH];
  logic [DATA_W-1:0] ent_target_s [DEPTH];
  logic [DATA_W-1:0] ent_addr_s   [DEPTH];

  logic              rs1_hit_s, rs2_hit_s;
  logic [DATA_W-1:0] rs1_bp_value_s, rs2_bp_value_s;
  logic [DATA_W-1:0] rs1_bp_target_s, rs2_bp_target_s, rs1_bp_addr_s, rs2_bp_addr_s;
  logic              unused_s;

  logic              alloc_fire_s, head_adv_s, store_start_s;
  logic              br_mispredict_s;
  rob_kind_e         head_kind_s;
  logic [DATA_W-1:0] head_pc_s, head_value_s, head_target_s, head_addr_s, br_redirect_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent_match
    rob_wb_match #(.NUM_WB(NUM_WB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match (
      .query_tag (TAG_W'(g)),
      .wb_valid  (wb_valid),
      .wb_tag    (wb_tag),
      .wb_value  (wb_value),
      .wb_target (wb_target),
      .wb_addr   (wb_addr),
      .hit       (ent_hit_s[g]),
      .value     (ent_value_s[g]),
      .target    (ent_target_s[g]),
      .addr      (ent_addr_s[g])
    );
  end

  rob_wb_match #(.NUM_WB(NUM_WB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs1_match (
    .query_tag (rs1_tag),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_value  (wb_value),
    .wb_target (wb_target),
    .wb_addr   (wb_addr),
    .hit       (rs1_hit_s),
    .value     (rs1_bp_value_s),
    .target    (rs1_bp_target_s),
    .addr      (rs1_bp_addr_s)
  );

  rob_wb_match #(.NUM_WB(NUM_WB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs2_match (
    .query_tag (rs2_tag),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_value  (wb_value),
    .wb_target (wb_target),
    .wb_addr   (wb_addr),
    .hit       (rs2_hit_s),
    .value     (rs2_bp_value_s),
    .target    (rs2_bp_target_s),
    .addr      (rs2_bp_addr_s)
  );

  assign unused_s = ^{rs1_bp_target_s, rs2_bp_target_s, rs1_bp_addr_s, rs2_bp_addr_s};

  assign alloc_ready  = (count_r != FULL_COUNT);
  assign alloc_tag    = tail_r;
  assign count        = count_r;
  assign alloc_fire_s = alloc_valid && alloc_ready;
  // Writebacks to entries that are not live are dropped.
  assign wb_we_s      = ent_hit_s & valid_r;

  assign rs1_ready = rs1_hit_s ? 1'b1 : ready_r[rs1_tag];
  assign rs2_ready = rs2_hit_s ? 1'b1 : ready_r[rs2_tag];
  assign rs1_value = rs1_hit_s ? rs1_bp_value_s : value_r[rs1_tag];
  assign rs2_value = rs2_hit_s ? rs2_bp_value_s : value_r[rs2_tag];

  assign head_kind_s     = kind_r[head_r];
  assign head_pc_s       = pc_r[head_r];
  assign head_value_s    = value_r[head_r];
  assign head_target_s   = target_r[head_r];
  assign head_addr_s     = addr_r[head_r];
  assign br_mispredict_s = (head_value_s[0] != pred_r[head_r]);
  assign br_redirect_s   = head_value_s[0] ? head_target_s : (head_pc_s + DATA_W'(4));

  // Commit decision for the head entry; an outstanding store blocks all other commits.
  always_comb begin
    head_adv_s    = 1'b0;
    store_start_s = 1'b0;
    if (flush_r) begin
      head_adv_s = 1'b0;
    end else if (st_valid_r) begin
      head_adv_s = st_done;
    end else if (valid_r[head_r] && ready_r[head_r]) begin
      case (head_kind_s)
        KIND_SB, KIND_SH, KIND_SW: store_start_s = 1'b1;
        default:                   head_adv_s    = 1'b1;
      endcase
    end else begin
      head_adv_s = 1'b0;
    end
  end

  // Control state, occupancy and registered commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= {TAG_W{1'b0}};
      tail_r      <= {TAG_W{1'b0}};
      count_r     <= {(TAG_W+1){1'b0}};
      valid_r     <= {DEPTH{1'b0}};
      ready_r     <= {DEPTH{1'b0}};
      reg_we_r    <= 1'b0;
      reg_rd_r    <= 5'd0;
      reg_value_r <= {DATA_W{1'b0}};
      reg_tag_r   <= {TAG_W{1'b0}};
      st_valid_r  <= 1'b0;
      st_size_r   <= 2'd0;
      st_addr_r   <= {DATA_W{1'b0}};
      st_value_r  <= {DATA_W{1'b0}};
      bp_update_r <= 1'b0;
      bp_idx_r    <= {BP_IDX_W{1'b0}};
      bp_taken_r  <= 1'b0;
      flush_r     <= 1'b0;
      flush_pc_r  <= {DATA_W{1'b0}};
    end else if (!rdy) begin
      reg_we_r    <= 1'b0;
      bp_update_r <= 1'b0;
      flush_r     <= 1'b0;
    end else if (flush_r) begin
      head_r      <= {TAG_W{1'b0}};
      tail_r      <= {TAG_W{1'b0}};
      count_r     <= {(TAG_W+1){1'b0}};
      valid_r     <= {DEPTH{1'b0}};
      ready_r     <= {DEPTH{1'b0}};
      reg_we_r    <= 1'b0;
      bp_update_r <= 1'b0;
      flush_r     <= 1'b0;
    end else begin
      reg_we_r    <= 1'b0;
      bp_update_r <= 1'b0;
      flush_r     <= 1'b0;
      ready_r     <= ready_r | wb_we_s;
      if (head_adv_s) begin
        valid_r[head_r] <= 1'b0;
        ready_r[head_r] <= 1'b0;
        head_r          <= head_r + TAG_W'(1);
      end
      if (alloc_fire_s) begin
        valid_r[tail_r] <= 1'b1;
        ready_r[tail_r] <= 1'b0;
        tail_r          <= tail_r + TAG_W'(1);
      end
      case ({alloc_fire_s, head_adv_s})
        2'b10:   count_r <= count_r + (TAG_W+1)'(1);
        2'b01:   count_r <= count_r - (TAG_W+1)'(1);
        default: count_r <= count_r;
      endcase

      if (store_start_s) begin
        st_valid_r <= 1'b1;
        st_size_r  <= store_size(head_kind_s);
        st_addr_r  <= head_addr_s;
        st_value_r <= head_value_s;
      end else if (st_valid_r && st_done) begin
        st_valid_r <= 1'b0;
      end

      if (head_adv_s && !st_valid_r) begin
        case (head_kind_s)
          KIND_REG, KIND_JALR: begin
            reg_we_r    <= 1'b1;
            reg_rd_r    <= rd_r[head_r];
            reg_value_r <= head_value_s;
            reg_tag_r   <= head_r;
            if (head_kind_s == KIND_JALR) begin
              flush_r    <= 1'b1;
              flush_pc_r <= head_target_s;
            end
          end
          KIND_BR: begin
            bp_update_r <= 1'b1;
            bp_idx_r    <= head_pc_s[BP_IDX_W+1:2];
            bp_taken_r  <= head_value_s[0];
            if (br_mispredict_s) begin
              flush_r    <= 1'b1;
              flush_pc_r <= br_redirect_s;
            end
          end
          default: reg_we_r <= 1'b0;
        endcase
      end
    end
  end

  // Entry payload storage; no reset needed since valid/ready gate every use.
  always_ff @(posedge clk) begin
    if (rdy && !rst && !flush_r) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_we_s[i]) begin
          value_r[i]  <= ent_value_s[i];
          target_r[i] <= ent_target_s[i];
          addr_r[i]   <= ent_addr_s[i];
        end
      end
      if (alloc_fire_s) begin
        kind_r[tail_r] <= rob_kind_e'(alloc_kind);
        rd_r[tail_r]   <= alloc_rd;
        pc_r[tail_r]   <= alloc_pc;
        pred_r[tail_r] <= alloc_pred_taken;
      end
    end
  end

  assign reg_we    = reg_we_r;
  assign reg_rd    = reg_rd_r;
  assign reg_value = reg_value_r;
  assign reg_tag   = reg_tag_r;
  assign st_valid  = st_valid_r;
  assign st_size   = st_size_r;
  assign st_addr   = st_addr_r;
  assign st_value  = st_value_r;
  assign bp_update = bp_update_r;
  assign bp_idx    = bp_idx_r;
  assign bp_taken  = bp_taken_r;
  assign flush     = flush_r;
  assign flush_pc  = flush_pc_r;

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: stimulus pushes expected commits into a queue,
// a negedge monitor pops and compares whenever a commit output appears.
module tb_rob_queue;
  import rob_pkg::*;

  localparam int DEPTH = 16, TAG_W = 4, DATA_W = 32, NUM_WB = 2, BP_IDX_W = 8;

  logic clk = 1'b0;
  logic rst, rdy, alloc_valid, alloc_ready, alloc_pred_taken;
  logic [TAG_W-1:0] alloc_tag, rs1_tag, rs2_tag, reg_tag;
  logic [2:0] alloc_kind;
  logic [4:0] alloc_rd, reg_rd;
  logic [DATA_W-1:0] alloc_pc, rs1_value, rs2_value, reg_value, st_addr, st_value, flush_pc;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_value, wb_target, wb_addr;
  logic rs1_ready, rs2_ready, reg_we, st_valid, st_done, bp_update, bp_taken, flush;
  logic [1:0] st_size;
  logic [BP_IDX_W-1:0] bp_idx;
  logic [TAG_W:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  tag;
    logic        bp;
    logic [7:0]  idx;
    logic        taken;
    logic        flush;
    logic [31:0] fpc;
    logic        st;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] sval;
  } ev_t;

  ev_t exp_q[$];

  rob_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB), .BP_IDX_W(BP_IDX_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_target(wb_target), .wb_addr(wb_addr),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .reg_we(reg_we), .reg_rd(reg_rd), .reg_value(reg_value), .reg_tag(reg_tag),
    .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_value(st_value),
    .st_done(st_done),
    .bp_update(bp_update), .bp_idx(bp_idx), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t ev_reg(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] tag);
    ev_t e = '0;
    e.reg_we = 1'b1; e.rd = rd; e.value = v; e.tag = tag;
    return e;
  endfunction

  function automatic ev_t ev_br(input logic [7:0] idx, input logic taken, input logic fl, input logic [31:0] fpc);
    ev_t e = '0;
    e.bp = 1'b1; e.idx = idx; e.taken = taken; e.flush = fl; e.fpc = fpc;
    return e;
  endfunction

  function automatic ev_t ev_st(input logic [1:0] size, input logic [31:0] a, input logic [31:0] v);
    ev_t e = '0;
    e.st = 1'b1; e.size = size; e.addr = a; e.sval = v;
    return e;
  endfunction

  // Monitor: compare every observed commit against the head of the expected queue.
  initial begin
    logic st_prev, st_rise;
    ev_t e;
    st_prev = 1'b0;
    forever begin
      @(negedge clk);
      st_rise = st_valid && !st_prev;
      st_prev = st_valid;
      if (!rst && (reg_we || bp_update || flush || st_rise)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got reg_we=%0b bp=%0b flush=%0b st=%0b, expected no commit",
                   reg_we, bp_update, flush, st_rise);
        end else begin
          e = exp_q.pop_front();
          chk("sb_reg_we", 32'(reg_we), 32'(e.reg_we));
          chk("sb_bp_update", 32'(bp_update), 32'(e.bp));
          chk("sb_flush", 32'(flush), 32'(e.flush));
          chk("sb_st_valid", 32'(st_rise), 32'(e.st));
          if (e.reg_we) begin
            chk("sb_reg_rd", 32'(reg_rd), 32'(e.rd));
            chk("sb_reg_value", reg_value, e.value);
            chk("sb_reg_tag", 32'(reg_tag), 32'(e.tag));
          end
          if (e.bp) begin
            chk("sb_bp_idx", 32'(bp_idx), 32'(e.idx));
            chk("sb_bp_taken", 32'(bp_taken), 32'(e.taken));
          end
          if (e.flush) chk("sb_flush_pc", flush_pc, e.fpc);
          if (e.st) begin
            chk("sb_st_size", 32'(st_size), 32'(e.size));
            chk("sb_st_addr", st_addr, e.addr);
            chk("sb_st_value", st_value, e.sval);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = '0; wb_tag = '0; wb_value = '0; wb_target = '0; wb_addr = '0;
  endtask

  task automatic set_wb(input int ch, input logic [3:0] tag, input logic [31:0] v,
                        input logic [31:0] t, input logic [31:0] a);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*TAG_W +: TAG_W] = tag;
    wb_value[ch*DATA_W +: DATA_W] = v;
    wb_target[ch*DATA_W +: DATA_W] = t;
    wb_addr[ch*DATA_W +: DATA_W] = a;
  endtask

  task automatic do_alloc(input logic [2:0] kind, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
    alloc_valid = 1'b1; alloc_kind = kind; alloc_rd = rd; alloc_pc = pc; alloc_pred_taken = pred;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((count != 5'd0 || flush) && k < 40) begin
      tick();
      k++;
    end
    chk(name, 32'(count), 32'd0);
  endtask

  task automatic run_one(input logic [2:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred, input logic [31:0] v, input logic [31:0] t);
    logic [3:0] tag;
    tag = alloc_tag;
    do_alloc(kind, rd, pc, pred);
    set_wb(1, tag, v, t, 32'h0);
    tick();
    clear_wb();
    wait_idle("run_one_idle");
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_kind = 3'd0; alloc_rd = 5'd0;
    alloc_pc = 32'h0; alloc_pred_taken = 1'b0; rs1_tag = 4'd0; rs2_tag = 4'd0; st_done = 1'b0;
    clear_wb();
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_st_valid", 32'(st_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_bp_update", 32'(bp_update), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);

    // Fill to 16 entries, then a refused 17th allocation.
    alloc_valid = 1'b1; alloc_kind = KIND_REG;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_rd = 5'(i + 1); alloc_pc = 32'h1000 + 32'(4 * i);
      tick();
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_rd = 5'd31;
    tick();
    alloc_valid = 1'b0;
    chk("full_ignore_count", 32'(count), 32'd16);
    chk("full_ignore_tail", 32'(alloc_tag), 32'd0);

    // Full queue: alloc on the same edge as a head commit is refused.
    exp_q.push_back(ev_reg(5'd1, 32'h100, 4'd0));
    set_wb(0, 4'd0, 32'h100, 32'h0, 32'h0);
    tick();
    clear_wb();
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("full_commit_count", 32'(count), 32'd15);
    chk("full_commit_tail", 32'(alloc_tag), 32'd0);

    // Freeze: commit blocked and a writeback during freeze is dropped.
    exp_q.push_back(ev_reg(5'd2, 32'h101, 4'd1));
    set_wb(0, 4'd1, 32'h101, 32'h0, 32'h0);
    tick();
    clear_wb();
    rdy = 1'b0;
    set_wb(0, 4'd2, 32'h102, 32'h0, 32'h0);
    tick();
    clear_wb();
    chk("freeze_reg_we", 32'(reg_we), 32'd0);
    chk("freeze_count", 32'(count), 32'd15);
    tick();
    chk("freeze_count2", 32'(count), 32'd15);
    rdy = 1'b1;
    tick();
    chk("thaw_reg_we", 32'(reg_we), 32'd1);
    chk("thaw_reg_tag", 32'(reg_tag), 32'd1);
    tick();
    chk("thaw_wb_dropped", 32'(count), 32'd14);

    for (int i = 2; i < DEPTH; i += 2) begin
      exp_q.push_back(ev_reg(5'(i + 1), 32'h100 + 32'(i), 4'(i)));
      exp_q.push_back(ev_reg(5'(i + 2), 32'h101 + 32'(i), 4'(i + 1)));
      set_wb(0, 4'(i), 32'h100 + 32'(i), 32'h0, 32'h0);
      set_wb(1, 4'(i + 1), 32'h101 + 32'(i), 32'h0, 32'h0);
      tick();
    end
    clear_wb();
    wait_idle("drain_idle");
    tick();

    // Single REG: wb at edge N, reg_we visible after edge N+1.
    do_alloc(KIND_REG, 5'd5, 32'h0, 1'b0);
    exp_q.push_back(ev_reg(5'd5, 32'h1234, 4'd0));
    set_wb(0, 4'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    clear_wb();
    chk("lat_reg_we_early", 32'(reg_we), 32'd0);
    tick();
    chk("lat_reg_we", 32'(reg_we), 32'd1);
    chk("lat_reg_rd", 32'(reg_rd), 32'd5);
    chk("lat_count", 32'(count), 32'd0);

    // Same-cycle bypass with priority, then discard of writeback to a dead entry.
    rs1_tag = 4'd3; rs2_tag = 4'd4;
    set_wb(0, 4'd3, 32'h11, 32'h0, 32'h0);
    set_wb(1, 4'd3, 32'hAA, 32'h0, 32'h0);
    #1;
    chk("byp_rs1_ready", 32'(rs1_ready), 32'd1);
    chk("byp_rs1_value", rs1_value, 32'hAA);
    chk("byp_rs2_ready", 32'(rs2_ready), 32'd0);
    tick();
    clear_wb();
    #1;
    chk("discard_rs1_ready", 32'(rs1_ready), 32'd0);
    set_wb(0, 4'd4, 32'h55, 32'h0, 32'h0);
    #1;
    chk("byp_rs2_ready2", 32'(rs2_ready), 32'd1);
    chk("byp_rs2_value", rs2_value, 32'h55);
    tick();
    clear_wb();

    // Store handshake holds the head until st_done.
    do_alloc(KIND_SW, 5'd0, 32'h200, 1'b0);
    do_alloc(KIND_REG, 5'd7, 32'h204, 1'b0);
    exp_q.push_back(ev_st(REQUIRE32, 32'h100, 32'hDEAD));
    exp_q.push_back(ev_reg(5'd7, 32'h77, 4'd2));
    set_wb(0, 4'd1, 32'hDEAD, 32'h0, 32'h100);
    set_wb(1, 4'd2, 32'h77, 32'h0, 32'h0);
    tick();
    clear_wb();
    tick();
    chk("st_start", 32'(st_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_hold_valid", 32'(st_valid), 32'd1);
      chk("st_hold_count", 32'(count), 32'd2);
      chk("st_hold_reg_we", 32'(reg_we), 32'd0);
    end
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    chk("st_done_valid", 32'(st_valid), 32'd0);
    chk("st_done_count", 32'(count), 32'd1);
    tick();
    chk("st_next_reg_we", 32'(reg_we), 32'd1);
    chk("st_next_reg_rd", 32'(reg_rd), 32'd7);
    chk("st_next_count", 32'(count), 32'd0);

    // Mispredicted taken branch flushes a younger entry.
    do_alloc(KIND_BR, 5'd0, 32'h40, 1'b0);
    do_alloc(KIND_REG, 5'd9, 32'h44, 1'b0);
    exp_q.push_back(ev_br(8'h10, 1'b1, 1'b1, 32'h80));
    set_wb(1, 4'd3, 32'h1, 32'h80, 32'h0);
    tick();
    clear_wb();
    tick();
    chk("br_bp_update", 32'(bp_update), 32'd1);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_count", 32'(count), 32'd1);
    alloc_valid = 1'b1; alloc_kind = KIND_REG; alloc_rd = 5'd3;
    set_wb(0, 4'd4, 32'h99, 32'h0, 32'h0);
    tick();
    alloc_valid = 1'b0;
    clear_wb();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("flush_done", 32'(flush), 32'd0);

    // JALR, not-taken mispredict and a correctly predicted branch.
    exp_q.push_back('{reg_we: 1'b1, rd: 5'd1, value: 32'h304, tag: 4'd0, bp: 1'b0, idx: 8'h0,
                      taken: 1'b0, flush: 1'b1, fpc: 32'h500, st: 1'b0, size: 2'd0,
                      addr: 32'h0, sval: 32'h0});
    run_one(KIND_JALR, 5'd1, 32'h300, 1'b0, 32'h304, 32'h500);
    exp_q.push_back(ev_br(8'h21, 1'b0, 1'b1, 32'h88));
    run_one(KIND_BR, 5'd0, 32'h84, 1'b1, 32'h0, 32'h200);
    exp_q.push_back(ev_br(8'hFF, 1'b1, 1'b0, 32'h0));
    run_one(KIND_BR, 5'd0, 32'h3FC, 1'b1, 32'h1, 32'h10);
    chk("br_ok_tail", 32'(alloc_tag), 32'd1);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
